mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter SHALL be: MAX_DM_BURST, 4, consecutive data grants allowed while fetch is waiting (range 1..15).
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 if_req  in  1  instruction-fetch request, held high until if_ready.
REQ-005 if_addr  in  32  fetch byte address, stable while if_req is high.
REQ-006 if_rdata  out  32  registered fetch data, valid in the if_ready cycle.
REQ-007 if_ready  out  1  one-cycle fetch completion pulse.
REQ-008 dm_req, dm_we  in  1 each  data request and write enable, held until dm_ready.
REQ-009 dm_addr, dm_wdata  in  32 each  data address and store data, stable while dm_req is high.
REQ-010 dm_rdata  out  32  registered load data; dm_ready  out  1  one-cycle data completion pulse.
REQ-011 mem_req, mem_we  out  1 each  request and write enable to the shared single-port memory.
REQ-012 mem_addr, mem_wdata  out  32 each  address and write data to memory; mem_rdata  in  32  read data.
REQ-013 mem_ack  in  1  one-cycle memory completion; mem_rdata SHALL be valid in the mem_ack cycle.
REQ-014 if_stall, dm_stall  out  1 each  pipeline freeze: requester's req high and its ready low.

Function
REQ-015 FSM states SHALL be IDLE, IF_BUSY, DM_BUSY, RESP.
REQ-016 IDLE: dm_req high and (if_req low or burst_cnt < MAX_DM_BURST) -> DM_BUSY; else if_req high -> IF_BUSY; else stay.
REQ-017 burst_cnt (4 bits) SHALL increment on each data grant while if_req is high, saturate at 15, and clear on any fetch grant or when if_req is low at a grant.
REQ-018 mem_req SHALL be high exactly in IF_BUSY/DM_BUSY; mem_addr, mem_we, mem_wdata SHALL be registered at grant and held constant until mem_ack.
REQ-019 In IF_BUSY, mem_we SHALL be 0 and mem_wdata SHALL hold its last value.
REQ-020 BUSY with mem_ack -> RESP; mem_rdata SHALL be captured into if_rdata or dm_rdata (dm_rdata only if dm_we=0) on that edge.
REQ-021 RESP: the granted requester's ready SHALL be high for exactly one cycle; next state SHALL be IDLE; requests SHALL NOT be sampled in RESP.
REQ-022 Zero-wait memory (ack in first BUSY cycle) SHALL give req-to-ready latency of 2 cycles; one transaction per 3 cycles maximum.
REQ-023 mem_ack outside BUSY states SHALL be ignored without changing state or outputs.
REQ-024 if_ready and dm_ready SHALL never be high in the same cycle.
REQ-025 A requester dropping req while BUSY (illegal) SHALL NOT abort the transaction; it completes through RESP.

Reset
REQ-026 On reset: state IDLE, burst_cnt 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, if_rdata 0, dm_rdata 0, if_ready 0, dm_ready 0.
REQ-027 Reset asserted mid-transaction SHALL abandon it; a mem_ack arriving after reset SHALL be ignored per REQ-023.

Configuration
REQ-028 Macro MEM_ARB_PERF_EN defined: add outputs perf_if_wait[31:0] and perf_dm_wait[31:0] counting cycles each stall signal is high, wrapping at 2^32, cleared by reset.
REQ-029 Macro MEM_ARB_PERF_EN undefined: those ports and counters SHALL NOT exist; all other behaviour identical.

Structure
REQ-030 Package mem_arb_pkg SHALL hold the FSM state type, the burst-counter width (4) and the default MAX_DM_BURST.
REQ-031 Sub-module mem_arb_perf SHALL implement the two counters, instantiated only under MEM_ARB_PERF_EN; no other sub-module.

Verification
REQ-032 if_req with if_addr=0x00000040; mem_ack in first BUSY cycle with mem_rdata=0x8C080004 -> if_ready in cycle 2 and if_rdata=0x8C080004.
REQ-033 if_req and dm_req both high at cycle 0 with dm_we=1, dm_addr=0x10, dm_wdata=0xDEADBEEF -> DM_BUSY first; memory sees mem_we=1 and mem_wdata=0xDEADBEEF; fetch granted next and dm_rdata unchanged.
REQ-034 if_req and dm_req held high continuously, MAX_DM_BURST=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-035 mem_ack delayed 5 cycles -> mem_addr constant throughout, if_stall high 7 cycles total, ready pulses once.
REQ-036 reset asserted in DM_BUSY, stray mem_ack one cycle after release -> state IDLE, no ready pulse, all outputs at reset values.
REQ-037 MEM_ARB_PERF_EN defined, REQ-035 scenario -> perf_if_wait=7.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg -- shared types and constants for the instruction/data memory
// arbiter.
//   arb_state_t      : arbiter FSM state encoding
//   BURST_W          : width of the data-burst counter
//   MAX_DM_BURST_DEF : default number of back-to-back data grants allowed
//                      while a fetch is waiting
//   burst_sat_inc    : saturating increment for the burst counter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_BUSY = 2'd1,
        ST_DM_BUSY = 2'd2,
        ST_RESP    = 2'd3
    } arb_state_t;

    localparam int BURST_W          = 4;
    localparam int MAX_DM_BURST_DEF = 4;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [BURST_W-1:0] burst_sat_inc(input logic [BURST_W-1:0] cnt);
        if (cnt == {BURST_W{1'b1}}) begin
            burst_sat_inc = cnt;
        end else begin
            burst_sat_inc = cnt + BURST_W'(1);
        end
    endfunction

endpackage

// File: rtl/mem_arb_perf.sv
// mem_arb_perf -- stall-cycle performance counters for mem_arbiter.
// Only instantiated when MEM_ARB_PERF_EN is defined.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   if_stall, dm_stall    : stall indications from the arbiter
//   perf_if_wait          : cycles if_stall was high (wraps at 2^32)
//   perf_dm_wait          : cycles dm_stall was high (wraps at 2^32)
module mem_arb_perf (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_stall,
    input  logic        dm_stall,
    output logic [31:0] perf_if_wait,
    output logic [31:0] perf_dm_wait
);

    // Free-running wait counters, each advancing while its stall is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_if_wait <= 32'd0;
            perf_dm_wait <= 32'd0;
        end else begin
            if (if_stall) begin
                perf_if_wait <= perf_if_wait + 32'd1;
            end
            if (dm_stall) begin
                perf_dm_wait <= perf_dm_wait + 32'd1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter -- arbitrates instruction-fetch and data requests onto one
// shared single-port memory. Data wins by default, but after MAX_DM_BURST
// consecutive data grants with a fetch waiting, the fetch is served.
// Every transaction runs IDLE -> BUSY -> RESP, so the fastest turnaround is
// one transaction per three cycles.
// Optional feature: define MEM_ARB_PERF_EN to add the perf_if_wait /
// perf_dm_wait stall-cycle counters.
// Ports:
//   clk, reset                       : clock, synchronous active-high reset
//   if_req/if_addr -> if_rdata/if_ready : fetch requester
//   dm_req/dm_we/dm_addr/dm_wdata -> dm_rdata/dm_ready : data requester
//   mem_req/mem_we/mem_addr/mem_wdata, mem_rdata/mem_ack : memory port
//   if_stall, dm_stall               : request pending and not yet ready
//   perf_if_wait, perf_dm_wait       : stall counters (MEM_ARB_PERF_EN only)
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_DM_BURST = MAX_DM_BURST_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        if_stall,
    output logic        dm_stall
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0] perf_if_wait,
    output logic [31:0] perf_dm_wait
`endif
);

    localparam logic [BURST_W-1:0] MAX_BURST_C = BURST_W'(MAX_DM_BURST);

    arb_state_t         state_r;
    arb_state_t         state_s;
    logic [BURST_W-1:0] burst_cnt_r;
    logic               grant_dm_s;
    logic               grant_if_s;
    logic               if_done_s;
    logic               dm_done_s;

    // Completion only counts in the matching BUSY state; stray acks vanish.
    assign if_done_s = (state_r == ST_IF_BUSY) && mem_ack;
    assign dm_done_s = (state_r == ST_DM_BUSY) && mem_ack;

    // Next-state and grant decode; requests are only looked at in IDLE.
    always_comb begin
        state_s    = state_r;
        grant_dm_s = 1'b0;
        grant_if_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (dm_req && (!if_req || (burst_cnt_r < MAX_BURST_C))) begin
                    state_s    = ST_DM_BUSY;
                    grant_dm_s = 1'b1;
                end else if (if_req) begin
                    state_s    = ST_IF_BUSY;
                    grant_if_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_IF_BUSY, ST_DM_BUSY: begin
                if (mem_ack) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = state_r;
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Data-burst counter: only meaningful while a fetch is actually waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            burst_cnt_r <= '0;
        end else if (grant_if_s) begin
            burst_cnt_r <= '0;
        end else if (grant_dm_s) begin
            if (if_req) begin
                burst_cnt_r <= burst_sat_inc(burst_cnt_r);
            end else begin
                burst_cnt_r <= '0;
            end
        end
    end

    // Memory command registers: loaded at grant, frozen until the ack.
    // A fetch leaves mem_wdata at whatever the last data grant put there.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
        end else if (grant_dm_s) begin
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
        end else if (grant_if_s) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
        end else if (if_done_s || dm_done_s) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
        end
    end

    // Response capture: ready pulses cover exactly the RESP cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_rdata <= 32'd0;
            dm_rdata <= 32'd0;
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
        end else begin
            if_ready <= if_done_s;
            dm_ready <= dm_done_s;
            if (if_done_s) begin
                if_rdata <= mem_rdata;
            end
            // mem_we still holds the granted dm_we here; stores keep dm_rdata.
            if (dm_done_s && !mem_we) begin
                dm_rdata <= mem_rdata;
            end
        end
    end

    assign if_stall = if_req && !if_ready;
    assign dm_stall = dm_req && !dm_ready;

`ifdef MEM_ARB_PERF_EN
    mem_arb_perf u_perf (
        .clk          (clk),
        .reset        (reset),
        .if_stall     (if_stall),
        .dm_stall     (dm_stall),
        .perf_if_wait (perf_if_wait),
        .perf_dm_wait (perf_dm_wait)
    );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- scoreboard bench for mem_arbiter. Stimulus pushes the
// expected memory command and requester response; independent monitors pop
// and compare when the DUT raises mem_req or a ready.
// Honours MEM_ARB_PERF_EN for the perf counter ports.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        model_ack;
    logic        stray_ack;
    logic        if_stall;
    logic        dm_stall;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_wait;
    logic [31:0] perf_dm_wait;
`endif

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_t;

    typedef struct {
        logic        is_dm;
        logic [31:0] rdata;
    } resp_t;

    mem_t  mem_q[$];
    resp_t resp_q[$];

    logic [31:0] exp_last_wdata = 32'd0;
    logic [31:0] exp_last_load  = 32'd0;
    int          ack_delay      = 0;
    int          if_stall_cnt   = 0;

    assign mem_ack = model_ack | stray_ack;

    mem_arbiter #(.MAX_DM_BURST(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ready  (dm_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .if_stall  (if_stall),
        .dm_stall  (dm_stall)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_if_wait (perf_if_wait),
        .perf_dm_wait (perf_dm_wait)
`endif
    );

    always #5 clk = ~clk;

    // Memory contents seen by the bench: one fixed word, everything else hashed.
    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h0000_0040) begin
            return 32'h8C08_0004;
        end
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic is_dm, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata);
        mem_t  m;
        resp_t r;
        m.we    = we;
        m.addr  = addr;
        m.wdata = is_dm ? wdata : exp_last_wdata;
        if (is_dm) exp_last_wdata = wdata;
        r.is_dm = is_dm;
        r.rdata = (is_dm && we) ? exp_last_load : mem_model(addr);
        if (is_dm && !we) exp_last_load = r.rdata;
        mem_q.push_back(m);
        resp_q.push_back(r);
    endtask

    // Memory responder: acks after ack_delay wait cycles of mem_req.
    initial begin
        int wait_cnt;
        wait_cnt  = 0;
        model_ack = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (mem_req && !reset) begin
                wait_cnt++;
                model_ack = (wait_cnt > ack_delay);
            end else begin
                wait_cnt  = 0;
                model_ack = 1'b0;
            end
            mem_rdata = mem_model(mem_addr);
        end
    end

    // Memory-side monitor: command at mem_req rise, then stability while busy.
    initial begin
        logic        prev;
        logic [31:0] cur_addr;
        logic [31:0] cur_wdata;
        mem_t        m;
        prev = 1'b0;
        cur_addr = 32'd0;
        cur_wdata = 32'd0;
        forever begin
            @(negedge clk);
            if (mem_req && !prev) begin
                if (mem_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL mem_unexpected: got addr %h expected no request", mem_addr);
                end else begin
                    m = mem_q.pop_front();
                    check("mem_we", 32'(mem_we), 32'(m.we));
                    check("mem_addr", mem_addr, m.addr);
                    check("mem_wdata", mem_wdata, m.wdata);
                end
                cur_addr  = mem_addr;
                cur_wdata = mem_wdata;
            end else if (mem_req) begin
                check("mem_addr_hold", mem_addr, cur_addr);
                check("mem_wdata_hold", mem_wdata, cur_wdata);
            end
            prev = mem_req;
        end
    end

    // Response monitor: every ready pulse must match the next expected response.
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            if (if_stall) if_stall_cnt++;
            if (if_ready && dm_ready) begin
                n_cmp++;
                n_err++;
                $display("FAIL both_ready: got if_ready=1 dm_ready=1 expected one at most");
            end
            if (if_ready || dm_ready) begin
                if (resp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_ready: got if=%0b dm=%0b expected none", if_ready, dm_ready);
                end else begin
                    r = resp_q.pop_front();
                    check("resp_port_is_dm", 32'(dm_ready), 32'(r.is_dm));
                    check("resp_rdata", r.is_dm ? dm_rdata : if_rdata, r.rdata);
                end
            end
        end
    end

    task automatic wait_ready(input logic is_dm, output int lat);
        lat = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (is_dm ? dm_ready : if_ready) return;
            lat++;
        end
        n_cmp++;
        n_err++;
        $display("FAIL ready_timeout: got no %s ready expected one within 100 cycles",
                 is_dm ? "dm" : "if");
        lat = -1;
    endtask

    // Fetch agent: keeps if_req high across n consecutive fetches.
    task automatic fetch_seq(input int n, input logic [31:0] base, output int lat);
        lat = 0;
        if_req = 1'b1;
        for (int k = 0; k < n; k++) begin
            if_addr = base + 32'(4 * k);
            wait_ready(1'b0, lat);
            @(posedge clk);
            #1;
        end
        if_req = 1'b0;
    endtask

    // Data agent: keeps dm_req high across n consecutive accesses.
    task automatic data_seq(input int n, input logic [31:0] base, input logic we,
                            input logic [31:0] wdata, output int lat);
        lat = 0;
        dm_req   = 1'b1;
        dm_we    = we;
        dm_wdata = wdata;
        for (int k = 0; k < n; k++) begin
            dm_addr = base + 32'(4 * k);
            wait_ready(1'b1, lat);
            @(posedge clk);
            #1;
        end
        dm_req = 1'b0;
        dm_we  = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_if_rdata"}, if_rdata, 32'd0);
        check({tag, "_dm_rdata"}, dm_rdata, 32'd0);
        check({tag, "_if_ready"}, 32'(if_ready), 32'd0);
        check({tag, "_dm_ready"}, 32'(dm_ready), 32'd0);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        if_req    = 1'b0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        stray_ack = 1'b0;
        ack_delay = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        mem_q.delete();
        resp_q.delete();
        exp_last_wdata = 32'd0;
        exp_last_load  = 32'd0;
        @(negedge clk);
        check_reset_vals("rst");
        check("rst_if_stall", 32'(if_stall), 32'd0);
        check("rst_dm_stall", 32'(dm_stall), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int lat_d;
        int lat_i;
        reset     = 1'b1;
        if_req    = 1'b0;
        if_addr   = 32'd0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = 32'd0;
        dm_wdata  = 32'd0;
        stray_ack = 1'b0;

        do_reset();

        // Zero-wait fetch: ready two cycles after request.
        push_exp(1'b0, 1'b0, 32'h0000_0040, 32'd0);
        fetch_seq(1, 32'h0000_0040, lat);
        check("fetch_latency", 32'(lat), 32'd2);

        // Stray ack in IDLE must change nothing.
        stray_ack = 1'b1;
        @(posedge clk);
        #1;
        stray_ack = 1'b0;
        @(negedge clk);
        check("stray_mem_req", 32'(mem_req), 32'd0);
        check("stray_mem_addr", mem_addr, 32'h0000_0040);
        check("stray_if_rdata", if_rdata, 32'h8C08_0004);
        @(posedge clk);
        #1;

        // Fetch dropping its request mid-transaction still completes.
        ack_delay = 2;
        push_exp(1'b0, 1'b0, 32'h0000_0200, 32'd0);
        if_addr = 32'h0000_0200;
        if_req  = 1'b1;
        @(posedge clk);
        #1;
        if_req = 1'b0;
        wait_ready(1'b0, lat);
        @(posedge clk);
        #1;
        ack_delay = 0;

        // Simultaneous store and fetch: data first, fetch sees last wdata.
        do_reset();
        push_exp(1'b1, 1'b0, 32'h0000_0020, 32'd0);
        data_seq(1, 32'h0000_0020, 1'b0, 32'd0, lat);
        push_exp(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        push_exp(1'b0, 1'b0, 32'h0000_0100, 32'd0);
        fork
            data_seq(1, 32'h0000_0010, 1'b1, 32'hDEAD_BEEF, lat_d);
            fetch_seq(1, 32'h0000_0100, lat_i);
        join
        check("store_latency", 32'(lat_d), 32'd2);
        check("fetch_after_store_latency", 32'(lat_i), 32'd5);
        check("dm_rdata_after_store", dm_rdata, 32'h0000_0020 ^ 32'h5A5A_0000);

        // Continuous contention: D,D,D,D,I,D,D,D,D,I.
        do_reset();
        for (int k = 0; k < 4; k++) push_exp(1'b1, 1'b0, 32'h0000_1000 + 32'(4 * k), 32'd0);
        push_exp(1'b0, 1'b0, 32'h0000_2000, 32'd0);
        for (int k = 4; k < 8; k++) push_exp(1'b1, 1'b0, 32'h0000_1000 + 32'(4 * k), 32'd0);
        push_exp(1'b0, 1'b0, 32'h0000_2004, 32'd0);
        fork
            data_seq(8, 32'h0000_1000, 1'b0, 32'd0, lat_d);
            fetch_seq(2, 32'h0000_2000, lat_i);
        join

        // Slow memory: five wait cycles, seven stall cycles.
        do_reset();
        ack_delay    = 5;
        if_stall_cnt = 0;
        push_exp(1'b0, 1'b0, 32'h0000_0080, 32'd0);
        fetch_seq(1, 32'h0000_0080, lat);
        check("slow_fetch_latency", 32'(lat), 32'd7);
        check("slow_if_stall_cycles", 32'(if_stall_cnt), 32'd7);
        @(negedge clk);
`ifdef MEM_ARB_PERF_EN
        check("perf_if_wait", perf_if_wait, 32'd7);
        check("perf_dm_wait", perf_dm_wait, 32'd0);
`endif
        @(posedge clk);
        #1;
        ack_delay = 0;

        // Reset in DM_BUSY, stray ack one cycle after release.
        do_reset();
        ack_delay = 10;
        push_exp(1'b1, 1'b0, 32'h0000_0030, 32'h1234_5678);
        dm_addr  = 32'h0000_0030;
        dm_wdata = 32'h1234_5678;
        dm_we    = 1'b0;
        dm_req   = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset  = 1'b1;
        dm_req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        resp_q.delete();
        exp_last_wdata = 32'd0;
        exp_last_load  = 32'd0;
        ack_delay = 0;
        @(posedge clk);
        #1;
        stray_ack = 1'b1;
        @(posedge clk);
        #1;
        stray_ack = 1'b0;
        @(negedge clk);
        check_reset_vals("abort");
        @(posedge clk);
        #1;
        push_exp(1'b0, 1'b0, 32'h0000_0044, 32'd0);
        fetch_seq(1, 32'h0000_0044, lat);
        check("post_abort_fetch_latency", 32'(lat), 32'd2);

        repeat (3) @(posedge clk);
        #1;
        check("resp_q_drained", 32'(resp_q.size()), 32'd0);
        check("mem_q_drained", 32'(mem_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
